// File: rtl/clarvi_bypass_regfile.sv
// Clarvi integer register file: NUM_READ combinational read ports with write-first bypass,
// one write port, and a sequencer that zeroes the array one entry per cycle after reset or on request.
module clarvi_bypass_regfile #(
    parameter int XLEN        = 64,
    parameter int DEPTH       = 32,
    parameter int NUM_READ    = 2,
    parameter bit ZERO_REG    = 1'b1,
    parameter int DEBUG_INDEX = 28,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear_req,
    output logic                       ready,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
    output logic [NUM_READ*XLEN-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    output logic [XLEN-1:0]            debug_data
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clear_ptr;
    logic [ADDR_W-1:0]   clear_ptr_next;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     regs [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state     <= state_next;
            clear_ptr <= clear_ptr_next;
        end
    end

    // The clear sequencer and the write port share the array's single write port,
    // so the clear simply takes it over and any user write during CLEAR is dropped.
    always_comb begin
        state_next     = state;
        clear_ptr_next = clear_ptr;
        mem_we         = 1'b0;
        mem_addr       = wr_addr;
        mem_wdata      = wr_data;
        unique case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clear_ptr;
                mem_wdata = '0;
                if (clear_ptr == LAST_PTR) begin
                    state_next     = READY;
                    clear_ptr_next = '0;
                end else begin
                    clear_ptr_next = clear_ptr + 1'b1;
                end
            end
            READY: begin
                mem_we = wr_en && in_range(wr_addr);
                if (clear_req) begin
                    state_next     = CLEAR;
                    clear_ptr_next = '0;
                end
            end
            default: begin
                state_next     = CLEAR;
                clear_ptr_next = '0;
            end
        endcase
    end

    assign ready = (state == READY);

    // No reset on the array itself so it can map onto block or distributed RAM.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            regs[mem_addr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            data = '0;
            if (!ready || (ZERO_REG && addr == '0) || !in_range(addr)) begin
                data = '0;
            end else if (wr_en && wr_addr == addr) begin
                data = wr_data;
            end else begin
                data = regs[addr];
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
    end

    // A debug index beyond the array simply reads as zero.
    if (DEBUG_INDEX < DEPTH) begin : g_debug
        assign debug_data = ready ? regs[DEBUG_INDEX] : '0;
    end else begin : g_no_debug
        assign debug_data = '0;
    end

endmodule

// File: tb/tb_clarvi_bypass_regfile.sv
// Directed bench for clarvi_bypass_regfile: default build, a ZERO_REG=0 build and a
// 32-bit / 24-entry / 3-port build, all sharing one clock and reset.
module tb_clarvi_bypass_regfile;

    logic clock = 1'b0;
    logic reset_n;

    logic         a_clear_req, a_ready, a_wr_en;
    logic [9:0]   a_rd_addr;
    logic [127:0] a_rd_data;
    logic [4:0]   a_wr_addr;
    logic [63:0]  a_wr_data, a_debug_data;

    logic         b_clear_req, b_ready, b_wr_en;
    logic [9:0]   b_rd_addr;
    logic [127:0] b_rd_data;
    logic [4:0]   b_wr_addr;
    logic [63:0]  b_wr_data, b_debug_data;

    logic         c_clear_req, c_ready, c_wr_en;
    logic [14:0]  c_rd_addr;
    logic [95:0]  c_rd_data;
    logic [4:0]   c_wr_addr;
    logic [31:0]  c_wr_data, c_debug_data;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clock = ~clock;

    clarvi_bypass_regfile dut_a (
        .clock(clock), .reset_n(reset_n), .clear_req(a_clear_req), .ready(a_ready),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .debug_data(a_debug_data)
    );

    clarvi_bypass_regfile #(.ZERO_REG(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .clear_req(b_clear_req), .ready(b_ready),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .debug_data(b_debug_data)
    );

    clarvi_bypass_regfile #(.XLEN(32), .DEPTH(24), .NUM_READ(3), .DEBUG_INDEX(20)) dut_c (
        .clock(clock), .reset_n(reset_n), .clear_req(c_clear_req), .ready(c_ready),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .wr_en(c_wr_en), .wr_addr(c_wr_addr),
        .wr_data(c_wr_data), .debug_data(c_debug_data)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic [63:0] wdata,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        a_wr_en   = we;
        a_wr_addr = waddr;
        a_wr_data = wdata;
        a_rd_addr = {ra1, ra0};
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        a_clear_req = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
        b_clear_req = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        c_clear_req = 1'b0; c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_rd_addr = '0;

        #12;
        checkOutput("rst_ready_a", 64'(a_ready), 64'd0);
        checkOutput("rst_ready_c", 64'(c_ready), 64'd0);
        #10;
        reset_n = 1'b1;

        // Power-up clear: ready after exactly DEPTH edges
        for (int i = 1; i <= 32; i++) begin
            step();
            checkOutput($sformatf("clr_ready_a_e%0d", i), 64'(a_ready), 64'(i == 32));
            checkOutput($sformatf("clr_ready_c_e%0d", i), 64'(c_ready), 64'(i >= 24));
            if (i == 10) begin
                applyStimulus(1'b0, 5'd0, 64'd0, 5'd28, 5'd3);
                checkOutput("clr_rd0_a", a_rd_data[63:0], 64'd0);
                checkOutput("clr_rd1_a", a_rd_data[127:64], 64'd0);
                checkOutput("clr_dbg_a", a_debug_data, 64'd0);
            end
        end
        checkOutput("clr_ready_b", 64'(b_ready), 64'd1);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
            checkOutput($sformatf("zeroed_p0_x%0d", i), a_rd_data[63:0], 64'd0);
            checkOutput($sformatf("zeroed_p1_x%0d", 31 - i), a_rd_data[127:64], 64'd0);
        end

        // Plain write then read on both ports
        applyStimulus(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
        checkOutput("wr_x5_p0", a_rd_data[63:0], 64'hDEADBEEF_CAFEF00D);
        checkOutput("wr_x5_p1", a_rd_data[127:64], 64'hDEADBEEF_CAFEF00D);

        // Bypass: x7 holds 0x99, same-cycle write of 0x1234 must win on port 0 only
        applyStimulus(1'b1, 5'd7, 64'h99, 5'd0, 5'd0);
        step();
        applyStimulus(1'b1, 5'd9, 64'h55, 5'd0, 5'd0);
        step();
        applyStimulus(1'b0, 5'd0, 64'd0, 5'd7, 5'd9);
        checkOutput("pre_byp_p0", a_rd_data[63:0], 64'h99);
        applyStimulus(1'b1, 5'd7, 64'h1234, 5'd7, 5'd9);
        checkOutput("byp_p0", a_rd_data[63:0], 64'h1234);
        checkOutput("byp_p1", a_rd_data[127:64], 64'h55);
        step();
        applyStimulus(1'b0, 5'd0, 64'd0, 5'd7, 5'd9);
        checkOutput("post_byp_p0", a_rd_data[63:0], 64'h1234);

        // x0: hardwired zero in A, ordinary register in B
        applyStimulus(1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd0);
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 64'hFFFF; b_rd_addr = '0;
        #1;
        checkOutput("x0_byp_a_p0", a_rd_data[63:0], 64'd0);
        checkOutput("x0_byp_a_p1", a_rd_data[127:64], 64'd0);
        checkOutput("x0_byp_b_p0", b_rd_data[63:0], 64'hFFFF);
        step();
        b_wr_en = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        checkOutput("x0_a_p0", a_rd_data[63:0], 64'd0);
        checkOutput("x0_a_p1", a_rd_data[127:64], 64'd0);
        checkOutput("x0_b_p0", b_rd_data[63:0], 64'hFFFF);
        checkOutput("x0_b_p1", b_rd_data[127:64], 64'hFFFF);

        // Debug port has no bypass
        applyStimulus(1'b1, 5'd28, 64'hAB, 5'd28, 5'd0);
        checkOutput("dbg_no_byp", a_debug_data, 64'd0);
        checkOutput("dbg_byp_p0", a_rd_data[63:0], 64'hAB);
        step();
        applyStimulus(1'b0, 5'd0, 64'd0, 5'd28, 5'd5);
        checkOutput("dbg_x28", a_debug_data, 64'hAB);

        // Clear request, with writes during CLEAR that must be dropped
        a_clear_req = 1'b1;
        step();
        a_clear_req = 1'b0;
        checkOutput("creq_ready", 64'(a_ready), 64'd0);
        checkOutput("creq_dbg", a_debug_data, 64'd0);
        checkOutput("creq_p0", a_rd_data[63:0], 64'd0);
        for (int i = 1; i <= 32; i++) begin
            if (i == 20) begin
                applyStimulus(1'b1, 5'd3, 64'h77, 5'd3, 5'd28);
                checkOutput("creq_no_byp", a_rd_data[63:0], 64'd0);
            end else if (i == 30) begin
                applyStimulus(1'b1, 5'd28, 64'h77, 5'd3, 5'd28);
            end else begin
                applyStimulus(1'b0, 5'd0, 64'd0, 5'd3, 5'd28);
            end
            step();
            if (i >= 31) checkOutput($sformatf("creq_ready_e%0d", i), 64'(a_ready), 64'(i == 32));
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 5'd3, 5'd28);
        checkOutput("creq_x3", a_rd_data[63:0], 64'd0);
        checkOutput("creq_x28", a_rd_data[127:64], 64'd0);
        checkOutput("creq_dbg_after", a_debug_data, 64'd0);
        applyStimulus(1'b0, 5'd0, 64'd0, 5'd5, 5'd7);
        checkOutput("creq_x5", a_rd_data[63:0], 64'd0);
        checkOutput("creq_x7", a_rd_data[127:64], 64'd0);

        // Narrow, non-power-of-2 build
        c_wr_en = 1'b1; c_wr_addr = 5'd3; c_wr_data = 32'hCAFE1234;
        step();
        c_wr_addr = 5'd30; c_wr_data = 32'h00000BAD;
        c_rd_addr = {5'd3, 5'd3, 5'd30};
        #1;
        checkOutput("c_oor_byp", 64'(c_rd_data[31:0]), 64'd0);
        checkOutput("c_x3_p1", 64'(c_rd_data[63:32]), 64'hCAFE1234);
        checkOutput("c_x3_p2", 64'(c_rd_data[95:64]), 64'hCAFE1234);
        step();
        c_wr_addr = 5'd20; c_wr_data = 32'h20202020;
        #1;
        checkOutput("c_oor_rd", 64'(c_rd_data[31:0]), 64'd0);
        checkOutput("c_dbg_pre", 64'(c_debug_data), 64'd0);
        step();
        c_wr_en = 1'b0;
        c_rd_addr = {5'd20, 5'd3, 5'd3};
        #1;
        checkOutput("c_dbg", 64'(c_debug_data), 64'h20202020);
        checkOutput("c_x3_p0", 64'(c_rd_data[31:0]), 64'hCAFE1234);
        checkOutput("c_x20_p2", 64'(c_rd_data[95:64]), 64'h20202020);

        c_clear_req = 1'b1;
        step();
        c_clear_req = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i >= 23) checkOutput($sformatf("c_creq_ready_e%0d", i), 64'(c_ready), 64'(i == 24));
        end
        checkOutput("c_creq_x3", 64'(c_rd_data[31:0]), 64'd0);

        // Asynchronous reset mid-operation restarts the clear
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_a", 64'(a_ready), 64'd0);
        checkOutput("async_rst_c", 64'(c_ready), 64'd0);
        #10;
        reset_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i >= 31) checkOutput($sformatf("rerst_ready_e%0d", i), 64'(a_ready), 64'(i == 32));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/clarvi_bypass_regfile.md
# clarvi_bypass_regfile

Parametrised multi-port integer register file for the Clarvi core, replacing the fixed 2-read/1-write, 64-bit, 32-entry file. It adds a configurable read-port count, write-to-read bypass (write-first) and a hardware clear sequencer. The sequencer zeroes every entry one per cycle after reset or on request, so the array stays free of reset logic and remains BRAM/LUTRAM-inferable. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, 64, data width in bits.
- DEPTH, 32, number of registers; ADDR_W = $clog2(DEPTH), derived, not overridable.
- NUM_READ, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 register 0 always reads as zero.
- DEBUG_INDEX, 28, register exposed on debug_data.

- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- clear_req  in  1  request a full re-clear; sampled only in READY.
- ready  out  1  high when the file is accepting writes and returning stored data.
- rd_addr  in  NUM_READ*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_READ*XLEN  read data; port i at bits [i*XLEN +: XLEN].
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  XLEN  write data.
- debug_data  out  XLEN  contents of register DEBUG_INDEX.

## Operation
- State machine with two states, CLEAR and READY, plus clear_ptr (ADDR_W bits).
- Reset (reset_n low): state=CLEAR, clear_ptr=0, ready=0, immediately and asynchronously. Array contents are not reset.
- CLEAR: each edge writes 0 to registers[clear_ptr] and increments clear_ptr.
  - The edge at which clear_ptr==DEPTH-1 moves to READY and sets ready=1. clear_ptr returns to 0.
  - wr_en is ignored and the write is dropped, never deferred.
  - clear_req is ignored.
  - All rd_data ports and debug_data read 0.
- READY:
  - wr_en=1 writes wr_data to registers[wr_addr] at the edge.
  - clear_req=1 at an edge moves to CLEAR with clear_ptr=0 and ready=0. A wr_en in that same cycle is still performed, but it is then overwritten by the clear.
- Reads are combinational, for each port i:
  - Not ready: 0.
  - ZERO_REG=1 and rd_addr_i==0: 0.
  - rd_addr_i >= DEPTH (non-power-of-2 DEPTH): 0.
  - Bypass: ready, wr_en=1 and wr_addr==rd_addr_i give wr_data in the same cycle.
  - Otherwise: registers[rd_addr_i].
- Writes to register 0 with ZERO_REG=1 are stored but never observable. Writes with wr_addr >= DEPTH are dropped.
- debug_data = registers[DEBUG_INDEX] when ready, else 0. It has no bypass and shows the new value the cycle after the write edge.
- All read ports are independent. Any number of ports may share an address, and all receive identical data.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*, state).
- Write latency: 1 edge. The stored value is visible without bypass from the cycle after the edge.
- Clear duration: exactly DEPTH edges after reset_n deasserts, or after the edge that accepts clear_req. ready rises after the DEPTH-th edge.
- reset_n asserted mid-clear or mid-operation restarts the clear from entry 0. Write and clear_ptr activity at that moment is abandoned.
- ready changes only on a clock edge, or asynchronously to 0 on reset.

## Test plan
- Reset release, DEPTH=32: ready=0 for edges 1..31, ready=1 after edge 32. All rd_data and debug_data read 0 during the clear; all registers read 0 afterwards.
- Write/read: write 0xDEADBEEF_CAFEF00D to x5, then read x5 on both ports the next cycle. Both return that value.
- Bypass: in the same cycle wr_en=1, wr_addr=7, wr_data=0x1234 and rd_addr0=7 (old value 0x99). rd_data0=0x1234 combinationally, and rd_data1 on an unrelated register is unaffected.
- Zero register: write 0xFFFF to x0 with ZERO_REG=1. All ports read 0 at x0, including in the bypass cycle. With ZERO_REG=0, x0 reads 0xFFFF.
- Clear request: fill x28=0xAB, then assert clear_req for 1 cycle. ready drops next cycle and debug_data=0. A wr_en issued during CLEAR has no effect, and x28 reads 0 after DEPTH edges.
- Parametrisation: XLEN=32, DEPTH=24, NUM_READ=3. rd_addr=30 returns 0, a write to 30 is dropped, three simultaneous reads of x3 match, and the clear takes 24 edges.
